// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life controller.
package gol_pkg;

  localparam int unsigned GRID_N = 16;
  localparam int unsigned GRID_W = GRID_N * GRID_N;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } gol_state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseLimit   = 2'd1,
    CauseStable  = 2'd2,
    CauseExtinct = 2'd3
  } halt_cause_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gol_tick_timer.sv
// 8-bit load/decrement down-counter; zero marks a due generation tick.
module gol_tick_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/gol_ctrl.sv
// Game of Life run controller: owns the grid register, paces generations and
// detects limit, stable and extinct halts. The next-state datapath is external.
module gol_ctrl
  import gol_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] seed,
  input  logic              load,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [7:0]        period,
  input  logic [15:0]       gen_limit,
  input  logic [GRID_W-1:0] grid_next,
  output logic [GRID_W-1:0] grid,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [15:0]       gen_count
);

  gol_state_e        state_q, state_d;
  halt_cause_e       cause_q, cause_d;
  logic [GRID_W-1:0] grid_q, grid_d;
  logic [15:0]       count_q, count_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic [7:0]        tmr_value;
  logic              tmr_dec;
  logic              tmr_zero;

  logic              check;
  logic              extinct;
  logic              stable;
  logic [15:0]       count_inc;
  logic              limit_hit;

  gol_tick_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  assign extinct   = (grid_q == '0);
  assign stable    = (grid_next == grid_q);
  assign count_inc = sat_inc16(count_q);
  // A limit below the current count can never match, only equality halts.
  assign limit_hit = (gen_limit != 16'd0) && (count_inc == gen_limit);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    grid_d    = grid_q;
    count_d   = count_q;
    tmr_load  = 1'b0;
    tmr_value = period;
    tmr_dec   = 1'b0;
    check     = 1'b0;

    if (load) begin
      state_d   = StIdle;
      cause_d   = CauseNone;
      grid_d    = seed;
      count_d   = 16'd0;
      tmr_load  = 1'b1;
      tmr_value = 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!stop) begin
            if (start) begin
              state_d  = StRun;
              tmr_load = 1'b1;
            end else if (step) begin
              check = 1'b1;
            end
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
          end else if (tmr_zero) begin
            check = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        StHalt: ;
        default: state_d = StIdle;
      endcase

      if (check) begin
        if (extinct) begin
          state_d = StHalt;
          cause_d = CauseExtinct;
        end else if (stable) begin
          state_d = StHalt;
          cause_d = CauseStable;
        end else begin
          grid_d   = grid_next;
          count_d  = count_inc;
          tmr_load = 1'b1;
          if (limit_hit) begin
            state_d = StHalt;
            cause_d = CauseLimit;
          end
        end
      end
    end

    done_d = (state_d == StHalt) && (state_q != StHalt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cause_q <= CauseNone;
      grid_q  <= '0;
      count_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      grid_q  <= grid_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign grid       = grid_q;
  assign running    = (state_q == StRun);
  assign done       = done_q;
  assign halt_cause = cause_q;
  assign gen_count  = count_q;

endmodule

// File: tb/tb_gol_ctrl.sv
// Bench for gol_ctrl: acts as the GOL datapath and checks directed scenarios
// plus random command streams against a cycle-indexed behavioural model.
module tb_gol_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] seed;
  logic         load, start, stop, step;
  logic [7:0]   period;
  logic [15:0]  gen_limit;
  logic [255:0] grid_next;
  logic [255:0] grid;
  logic         running;
  logic         done;
  logic [1:0]   halt_cause;
  logic [15:0]  gen_count;

  int checks = 0;
  int errors = 0;

  logic [255:0] blink_h, blink_v, block_p;

  always #5 clk = ~clk;

  gol_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .load       (load),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .period     (period),
    .gen_limit  (gen_limit),
    .grid_next  (grid_next),
    .grid       (grid),
    .running    (running),
    .done       (done),
    .halt_cause (halt_cause),
    .gen_count  (gen_count)
  );

  // Conway rules on a 16x16 torus.
  function automatic logic [255:0] life(input logic [255:0] g);
    logic [255:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              cnt += int'(g[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
          end
        end
        n[r * 16 + c] = (cnt == 3) || (g[r * 16 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign grid_next = life(grid);

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    reset = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
  endtask

  task automatic load_seed(input logic [255:0] s);
    seed = s;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    clear_cmds();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++;
    if (grid !== 256'd0) begin
      errors++;
      $display("FAIL reset_grid: got %h want 0", grid);
    end
    checks++;
    if ({running, done, halt_cause, gen_count} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got run=%b done=%b cause=%0d cnt=%0d want all 0",
               running, done, halt_cause, gen_count);
    end
  endtask

  task automatic test_blinker_limit();
    clear_cmds();
    period    = 8'd0;
    gen_limit = 16'd4;
    load_seed(blink_h);
    checks++;
    if (grid !== blink_h || gen_count !== 16'd0) begin
      errors++;
      $display("FAIL blink_load: got grid %h cnt %0d want %h cnt 0", grid, gen_count, blink_h);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL blink_start_running: got %b want 1", running);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if (gen_count !== 16'(i) || grid !== ((i % 2) ? blink_v : blink_h)) begin
        errors++;
        $display("FAIL blink_gen%0d: got cnt %0d grid %h", i, gen_count, grid);
      end
      checks++;
      if (done !== (i == 4) || running !== (i != 4)) begin
        errors++;
        $display("FAIL blink_state%0d: got done %b run %b want done %b run %b",
                 i, done, running, i == 4, i != 4);
      end
    end
    checks++;
    if (halt_cause !== 2'd1) begin
      errors++;
      $display("FAIL blink_cause: got %0d want 1", halt_cause);
    end
    cycle();
    checks++;
    if (done !== 1'b0 || halt_cause !== 2'd1 || gen_count !== 16'd4 || grid !== blink_h) begin
      errors++;
      $display("FAIL blink_hold: got done %b cause %0d cnt %0d", done, halt_cause, gen_count);
    end
  endtask

  task automatic test_block_stable();
    clear_cmds();
    period    = 8'd0;
    gen_limit = 16'd0;
    load_seed(block_p);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    checks++;
    if (done !== 1'b1 || halt_cause !== 2'd2 || gen_count !== 16'd0 || grid !== block_p) begin
      errors++;
      $display("FAIL block_stable: got done %b cause %0d cnt %0d want 1 2 0",
               done, halt_cause, gen_count);
    end
    start = 1'b1;
    step  = 1'b1;
    cycle();
    clear_cmds();
    checks++;
    if (running !== 1'b0 || done !== 1'b0 || halt_cause !== 2'd2 || grid !== block_p) begin
      errors++;
      $display("FAIL block_halt_ignores: got run %b done %b cause %0d", running, done, halt_cause);
    end
  endtask

  task automatic test_extinct_step();
    clear_cmds();
    gen_limit = 16'd0;
    load_seed(256'd0);
    step = 1'b1;
    cycle();
    step = 1'b0;
    checks++;
    if (done !== 1'b1 || halt_cause !== 2'd3 || gen_count !== 16'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL extinct_step: got done %b cause %0d cnt %0d want 1 3 0",
               done, halt_cause, gen_count);
    end
    cycle();
    checks++;
    if (done !== 1'b0 || halt_cause !== 2'd3) begin
      errors++;
      $display("FAIL extinct_pulse: got done %b cause %0d want 0 3", done, halt_cause);
    end
  endtask

  task automatic test_cadence_stop();
    int exp_cnt;
    logic exp_run;
    clear_cmds();
    period    = 8'd3;
    gen_limit = 16'd0;
    load_seed(blink_h);
    for (int e = 0; e <= 14; e++) begin
      start = (e == 0) || (e == 9);
      stop  = (e == 6);
      cycle();
      clear_cmds();
      exp_cnt = (e >= 13) ? 2 : (e >= 4) ? 1 : 0;
      exp_run = (e <= 5) || (e >= 9);
      checks++;
      if (gen_count !== 16'(exp_cnt) || running !== exp_run) begin
        errors++;
        $display("FAIL cadence_e%0d: got cnt %0d run %b want cnt %0d run %b",
                 e, gen_count, running, exp_cnt, exp_run);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_cmds();
    period    = 8'd3;
    gen_limit = 16'd0;
    load_seed(blink_h);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (grid !== 256'd0 || {running, done, halt_cause, gen_count} !== 20'd0) begin
      errors++;
      $display("FAIL midrun_reset: got run %b done %b cause %0d cnt %0d grid %h",
               running, done, halt_cause, gen_count, grid);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (running !== (k < 4) || done !== (k == 4)) begin
        errors++;
        $display("FAIL midrun_restart%0d: got run %b done %b", k, running, done);
      end
    end
    checks++;
    if (halt_cause !== 2'd3 || gen_count !== 16'd0) begin
      errors++;
      $display("FAIL midrun_extinct: got cause %0d cnt %0d want 3 0", halt_cause, gen_count);
    end
  endtask

  task automatic test_load_priority();
    clear_cmds();
    period    = 8'd0;
    gen_limit = 16'd0;
    load_seed(blink_h);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    checks++;
    if (gen_count !== 16'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL prio_prerun: got cnt %0d run %b want 3 1", gen_count, running);
    end
    seed  = block_p;
    load  = 1'b1;
    start = 1'b1;
    cycle();
    clear_cmds();
    checks++;
    if (running !== 1'b0 || gen_count !== 16'd0 || grid !== block_p || halt_cause !== 2'd0) begin
      errors++;
      $display("FAIL prio_load_start: got run %b cnt %0d cause %0d", running, gen_count,
               halt_cause);
    end
    cycle();
    checks++;
    if (running !== 1'b0 || grid !== block_p) begin
      errors++;
      $display("FAIL prio_stays_idle: got run %b", running);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 halt; in run the tick falls due on an absolute
  // edge number fixed when the pacing interval is (re)started.
  int           m_mode, m_due;
  logic [255:0] m_grid;
  logic [15:0]  m_count;
  logic [1:0]   m_cause;
  logic         m_done;

  task automatic model_check(input int t);
    logic [255:0] nxt;
    nxt = life(m_grid);
    if (m_grid == 256'd0) begin
      m_mode  = 2;
      m_cause = 2'd3;
    end else if (nxt == m_grid) begin
      m_mode  = 2;
      m_cause = 2'd2;
    end else begin
      m_grid  = nxt;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      m_due   = t + int'(period) + 1;
      if (gen_limit != 16'd0 && m_count == gen_limit) begin
        m_mode  = 2;
        m_cause = 2'd1;
      end
    end
  endtask

  task automatic model_edge(input int t);
    int prev;
    prev = m_mode;
    if (reset) begin
      m_mode  = 0;
      m_grid  = '0;
      m_count = 16'd0;
      m_cause = 2'd0;
      m_done  = 1'b0;
      return;
    end
    if (load) begin
      m_mode  = 0;
      m_grid  = seed;
      m_count = 16'd0;
      m_cause = 2'd0;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (t == m_due) model_check(t);
    end else if (m_mode == 0) begin
      if (!stop) begin
        if (start) begin
          m_mode = 1;
          m_due  = t + int'(period) + 1;
        end else if (step) begin
          model_check(t);
        end
      end
    end
    m_done = (m_mode == 2) && (prev != 2);
  endtask

  task automatic test_random();
    int sel;
    logic [255:0] s;
    clear_cmds();
    reset     = 1'b1;
    period    = 8'd0;
    gen_limit = 16'd0;
    model_edge(0);
    cycle();
    for (int t = 1; t <= 600; t++) begin
      clear_cmds();
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 99) < 4);
      stop  = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 12);
      step  = ($urandom_range(0, 99) < 8);
      if (load) begin
        sel = $urandom_range(0, 9);
        for (int w = 0; w < 8; w++) s[w * 32 +: 32] = $urandom & $urandom;
        seed = (sel == 0) ? 256'd0 : (sel == 1) ? block_p : (sel == 2) ? blink_h : s;
        gen_limit = 16'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 19) == 0) period = 8'($urandom_range(0, 4));
      model_edge(t);
      cycle();
      checks++;
      if (grid !== m_grid) begin
        errors++;
        $display("FAIL rnd_grid t=%0d: got %h want %h", t, grid, m_grid);
      end
      checks++;
      if (gen_count !== m_count || halt_cause !== m_cause) begin
        errors++;
        $display("FAIL rnd_count_cause t=%0d: got %0d/%0d want %0d/%0d",
                 t, gen_count, halt_cause, m_count, m_cause);
      end
      checks++;
      if (running !== (m_mode == 1) || done !== m_done) begin
        errors++;
        $display("FAIL rnd_state t=%0d: got run %b done %b want run %b done %b",
                 t, running, done, m_mode == 1, m_done);
      end
    end
    clear_cmds();
  endtask

  initial begin
    blink_h = '0;
    blink_h[118] = 1'b1;
    blink_h[119] = 1'b1;
    blink_h[120] = 1'b1;
    blink_v = '0;
    blink_v[103] = 1'b1;
    blink_v[119] = 1'b1;
    blink_v[135] = 1'b1;
    block_p = '0;
    block_p[0]  = 1'b1;
    block_p[1]  = 1'b1;
    block_p[16] = 1'b1;
    block_p[17] = 1'b1;
    seed      = '0;
    period    = 8'd0;
    gen_limit = 16'd0;
    m_mode    = 0;
    m_due     = 0;
    m_grid    = '0;
    m_count   = 16'd0;
    m_cause   = 2'd0;
    m_done    = 1'b0;

    test_reset();
    test_blinker_limit();
    test_block_stable();
    test_extinct_step();
    test_cadence_stop();
    test_reset_mid_run();
    test_load_priority();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
